processing_element_mm: RTL

PROCESSING_ELEMENT_MM -- requirements
Module: processing_element_mm

---
 rtl/processing_element_mm.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/processing_element_mm.sv
// rtl/processing_element_mm.sv - systolic MAC processing element
// Output-stationary accumulate or weight-stationary partial-sum pass, with operand forwarding.
module processing_element_mm #(
   parameter int WIDTH_A     = 16,
   parameter int WIDTH_B     = 16,
   parameter int WIDTH_MAC   = 48,
   parameter int WIDTH_K     = 8,
   parameter int SIGNED      = 0,
   parameter int ZERO_GATING = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 mode,
   input  logic [WIDTH_K-1:0]   k_len,
   input  logic [WIDTH_A-1:0]   act_in,
   input  logic [WIDTH_B-1:0]   wei_in,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic                 wei_load,
   input  logic [WIDTH_MAC-1:0] psum_in,
   output logic [WIDTH_A-1:0]   act_out,
   output logic [WIDTH_B-1:0]   wei_out,
   output logic                 fwd_vld,
   output logic [WIDTH_MAC-1:0] res_out,
   output logic                 res_vld,
   input  logic                 res_rdy,
   output logic                 busy
);
   localparam int WP = WIDTH_A + WIDTH_B;

   typedef enum logic [1:0] {IDLE, OS_ACC, OS_FULL, WS_RUN} state_t;

   state_t               state_q;
   logic [WIDTH_MAC-1:0] acc_q, res_q;
   logic [WIDTH_K-1:0]   cnt_q;
   logic [WIDTH_B-1:0]   wreg_q, wei_out_q;
   logic [WIDTH_A-1:0]   act_out_q, op_a_q;
   logic [WIDTH_B-1:0]   op_b_q;
   logic                 res_vld_q, fwd_vld_q;

   logic                 accept, ws_path, zero, os_beat, ws_beat, last;
   logic [WIDTH_B-1:0]   mul_b_raw;
   logic [WIDTH_A-1:0]   mul_a;
   logic [WIDTH_B-1:0]   mul_b;
   logic [WP-1:0]        ext_a, ext_b, prod_p;
   logic [WIDTH_MAC-1:0] prod, acc_d;
   logic [WIDTH_K-1:0]   k_eff, cnt_d;

   // The weight operand comes from the stationary register whenever the beat belongs to WS.
   assign ws_path   = (state_q == WS_RUN) || ((state_q == IDLE) && mode);
   assign mul_b_raw = ws_path ? wreg_q : wei_in;
   assign zero      = (ZERO_GATING != 0) && ((act_in == '0) || (mul_b_raw == '0));

   // Zero beats keep the multiplier inputs frozen so the array does not toggle.
   assign mul_a  = zero ? op_a_q : act_in;
   assign mul_b  = zero ? op_b_q : mul_b_raw;
   assign ext_a  = {{WIDTH_B{(SIGNED != 0) && mul_a[WIDTH_A-1]}}, mul_a};
   assign ext_b  = {{WIDTH_A{(SIGNED != 0) && mul_b[WIDTH_B-1]}}, mul_b};
   assign prod_p = ext_a * ext_b;
   assign prod   = zero ? '0 : {{(WIDTH_MAC-WP){(SIGNED != 0) && prod_p[WP-1]}}, prod_p};

   assign k_eff = (k_len == '0) ? WIDTH_K'(1) : k_len;
   assign last  = (cnt_q == k_eff - WIDTH_K'(1));
   assign acc_d = acc_q + prod;
   assign cnt_d = cnt_q + WIDTH_K'(1);

   always_comb begin
      in_rdy = 1'b1;
      case (state_q)
         IDLE:    in_rdy = !(mode && wei_load);
         OS_ACC:  in_rdy = 1'b1;
         OS_FULL: in_rdy = 1'b0;
         WS_RUN:  in_rdy = !wei_load && (!res_vld_q || res_rdy);
         default: in_rdy = 1'b0;
      endcase
      if (rst || clear) in_rdy = 1'b0;
   end

   assign accept  = in_vld && in_rdy;
   assign os_beat = accept && !ws_path;
   assign ws_beat = accept && ws_path;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         act_out_q <= '0;
         wei_out_q <= '0;
         fwd_vld_q <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         if (rst) wreg_q <= '0;
      end else begin
         fwd_vld_q <= accept;
         if (accept) begin
            act_out_q <= act_in;
            wei_out_q <= ws_path ? wreg_q : wei_in;
         end
         if (accept && !zero) begin
            op_a_q <= act_in;
            op_b_q <= mul_b_raw;
         end
         if (res_vld_q && res_rdy) res_vld_q <= 1'b0;
         if (ws_path && wei_load) begin
            wreg_q    <= wei_in;
            wei_out_q <= wei_in;
         end

         if (os_beat) begin
            state_q <= OS_ACC;
            if (!last) begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
            end else if (!res_vld_q || res_rdy) begin
               res_q     <= acc_d;
               res_vld_q <= 1'b1;
               acc_q     <= '0;
               cnt_q     <= '0;
            end else begin
               acc_q   <= acc_d;
               state_q <= OS_FULL;
            end
         end

         if (ws_beat) begin
            res_q     <= psum_in + prod;
            res_vld_q <= 1'b1;
            state_q   <= WS_RUN;
         end

         case (state_q)
            OS_FULL: if (res_rdy) begin
               res_q     <= acc_q;
               res_vld_q <= 1'b1;
               acc_q     <= '0;
               cnt_q     <= '0;
               state_q   <= OS_ACC;
            end
            OS_ACC: if (!accept && (cnt_q == '0) && !res_vld_q) state_q <= IDLE;
            WS_RUN: if (!res_vld_q && !in_vld) state_q <= IDLE;
            default: ;
         endcase
      end
   end

   assign act_out = act_out_q;
   assign wei_out = wei_out_q;
   assign fwd_vld = fwd_vld_q;
   assign res_out = res_q;
   assign res_vld = res_vld_q;
   assign busy    = (state_q != IDLE);
endmodule
